// File: rtl/win_div_16_signed_seq.sv
// Iterative signed divider: one 16-bit lane or two independent 8-bit lanes.
// Restoring shift-subtract on magnitudes, signs applied in a final fix-up cycle.
module win_div_16_signed_seq #(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   div_a,
   input  logic [DATA_W-1:0]   div_b,
   input  logic [1:0]          bitwidth,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DATA_W-1:0] div_out,
   output logic [1:0]          div_by_zero
);

   localparam int W  = DATA_W;
   localparam int H  = DATA_W / 2;
   localparam int CW = $clog2(DATA_W);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_ITER = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   function automatic logic [W:0] abs_w(input logic [W-1:0] x);
      logic [W:0] e;
      e = {x[W-1], x};
      return x[W-1] ? -e : e;
   endfunction

   function automatic logic [H:0] abs_h(input logic [H-1:0] x);
      logic [H:0] e;
      e = {x[H-1], x};
      return x[H-1] ? -e : e;
   endfunction

   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dual_q;
   logic [W-1:0]    a_q, b_q;
   logic [1:0]      qneg_q, rneg_q, dz_q;
   logic [W-1:0]    qs0_q, rem0_q;
   logic [W:0]      dv0_q;
   logic [H-1:0]    qs1_q, rem1_q;
   logic [H:0]      dv1_q;
   logic [2*W-1:0]  out_q, out_d;
   logic [1:0]      dbz_q;

   logic [W:0]      fa, fb, t0, sub0;
   logic [H:0]      la, lb, ha, hb, t1, sub1;
   logic            ge0, ge1;
   logic [CW-1:0]   last;
   logic [W-1:0]    qm0, rm0, q0, r0;
   logic [H-1:0]    q1, r1;
   logic            unused;

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign div_out     = out_q;
   assign div_by_zero = dbz_q;

   assign fa = abs_w(a_q);
   assign fb = abs_w(b_q);
   assign la = abs_h(a_q[H-1:0]);
   assign lb = abs_h(b_q[H-1:0]);
   assign ha = abs_h(a_q[W-1:H]);
   assign hb = abs_h(b_q[W-1:H]);

   // Partial remainder is one bit wider than the lane to hold the compare.
   assign t0   = {rem0_q, qs0_q[W-1]};
   assign sub0 = t0 - dv0_q;
   assign ge0  = (t0 >= dv0_q);
   assign t1   = {rem1_q, qs1_q[H-1]};
   assign sub1 = t1 - dv1_q;
   assign ge1  = (t1 >= dv1_q);

   assign last   = dual_q ? CW'(H - 1) : CW'(W - 1);
   assign unused = ^{fa[W], la[H], ha[H], sub0[W], sub1[H]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = S_PREP;
         S_PREP: begin
            state_d = S_ITER;
            cnt_d   = '0;
         end
         S_ITER: begin
            if (cnt_q == last) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIX:  state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      qm0 = dual_q ? {{H{1'b0}}, qs0_q[H-1:0]} : qs0_q;
      rm0 = rem0_q;
      q0  = qneg_q[0] ? -qm0 : qm0;
      r0  = rneg_q[0] ? -rm0 : rm0;
      if (dz_q[0]) begin
         q0 = '1;
         r0 = dual_q ? {{H{1'b0}}, a_q[H-1:0]} : a_q;
      end
      q1 = qneg_q[1] ? -qs1_q : qs1_q;
      r1 = rneg_q[1] ? -rem1_q : rem1_q;
      if (dz_q[1]) begin
         q1 = '1;
         r1 = a_q[W-1:H];
      end
      out_d = dual_q ? {q1, r1, q0[H-1:0], r0[H-1:0]} : {q0, r0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dual_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         qneg_q  <= '0;
         rneg_q  <= '0;
         dz_q    <= '0;
         qs0_q   <= '0;
         rem0_q  <= '0;
         dv0_q   <= '0;
         qs1_q   <= '0;
         rem1_q  <= '0;
         dv1_q   <= '0;
         out_q   <= '0;
         dbz_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q    <= div_a;
                  b_q    <= div_b;
                  dual_q <= (bitwidth == 2'b11);
               end
            end
            S_PREP: begin
               rem0_q <= '0;
               rem1_q <= '0;
               if (dual_q) begin
                  // Low lane sits in the top half so both modes shift from bit W-1.
                  qs0_q  <= {la[H-1:0], {H{1'b0}}};
                  dv0_q  <= {{H{1'b0}}, lb};
                  qs1_q  <= ha[H-1:0];
                  dv1_q  <= hb;
                  qneg_q <= {a_q[W-1] ^ b_q[W-1], a_q[H-1] ^ b_q[H-1]};
                  rneg_q <= {a_q[W-1], a_q[H-1]};
                  dz_q   <= {b_q[W-1:H] == '0, b_q[H-1:0] == '0};
               end else begin
                  qs0_q  <= fa[W-1:0];
                  dv0_q  <= fb;
                  qs1_q  <= '0;
                  dv1_q  <= '0;
                  qneg_q <= {1'b0, a_q[W-1] ^ b_q[W-1]};
                  rneg_q <= {1'b0, a_q[W-1]};
                  dz_q   <= {1'b0, b_q == '0};
               end
            end
            S_ITER: begin
               rem0_q <= ge0 ? sub0[W-1:0] : t0[W-1:0];
               qs0_q  <= {qs0_q[W-2:0], ge0};
               rem1_q <= ge1 ? sub1[H-1:0] : t1[H-1:0];
               qs1_q  <= {qs1_q[H-2:0], ge1};
            end
            S_FIX: begin
               out_q <= out_d;
               dbz_q <= dz_q;
            end
            default: ;
         endcase
      end
   end

endmodule
